// File: rtl/irq_ctrl.sv
// Interrupt controller in front of the mips core: synchronises N_SRC async
// lines, latches rising edges as pending bits and hands one at a time to the core.
module irq_ctrl #(
  parameter int N_SRC       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             irq_ack,
  input  logic             irq_eret,
  output logic             interrupter,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [N_SRC-1:0] irq_pending,
  output logic [7:0]       irq_lost
);

  localparam int WARM   = SYNC_STAGES + 1;
  localparam int WARM_W = $clog2(WARM + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC} state_t;

  logic [N_SRC-1:0]  r_sync [SYNC_STAGES];
  logic [N_SRC-1:0]  r_hist;
  logic [N_SRC-1:0]  r_pending;
  logic [WARM_W-1:0] r_warm;
  logic [7:0]        r_lost;
  logic [ID_W-1:0]   r_id;
  logic              r_interrupter;
  logic              r_in_service;
  state_t            r_state;
  state_t            w_state_next;

  logic              w_armed;
  logic [N_SRC-1:0]  w_edge;
  logic [N_SRC-1:0]  w_clear;
  logic [N_SRC-1:0]  w_cand;
  logic [N_SRC-1:0]  w_lost_evt;
  logic [ID_W-1:0]   w_win;
  logic [3:0]        w_lost_inc;
  logic [8:0]        w_lost_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync[0] <= '0;
    end else begin
      r_sync[0] <= irq_src;
    end
  end

  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_sync[gi] <= '0;
      end else begin
        r_sync[gi] <= r_sync[gi-1];
      end
    end
  end

  // Edges stay gated until the history flop holds a post-reset sample, so a
  // line already high when reset releases is not mistaken for a new event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_warm <= '0;
    end else begin
      r_hist <= r_sync[SYNC_STAGES-1];
      if (!w_armed) begin
        r_warm <= r_warm + 1'b1;
      end
    end
  end

  assign w_armed    = (r_warm == WARM_W'(WARM));
  assign w_edge     = w_armed ? (r_sync[SYNC_STAGES-1] & ~r_hist) : '0;
  assign w_clear    = (r_state == S_REQ && irq_ack) ? (N_SRC'(1) << r_id) : '0;
  assign w_cand     = r_pending & irq_mask;
  assign w_lost_evt = w_edge & r_pending & ~w_clear;

  always_comb begin
    w_lost_inc = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_lost_inc = w_lost_inc + {3'b000, w_lost_evt[i]};
    end
    w_lost_sum = {1'b0, r_lost} + {5'b00000, w_lost_inc};
  end

  always_comb begin
    w_win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_win = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (|w_cand)  w_state_next = S_REQ;
      S_REQ:   if (irq_ack)  w_state_next = S_SVC;
      S_SVC:   if (irq_eret) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_id          <= '0;
      r_pending     <= '0;
      r_lost        <= '0;
      r_interrupter <= 1'b0;
      r_in_service  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_interrupter <= (w_state_next == S_REQ);
      r_in_service  <= (w_state_next == S_SVC);
      // A new edge on the acked source wins over the clear.
      r_pending     <= (r_pending & ~w_clear) | w_edge;
      r_lost        <= (w_lost_sum > 9'd255) ? 8'hFF : w_lost_sum[7:0];
      if (r_state == S_IDLE && |w_cand) begin
        r_id <= w_win;
      end
    end
  end

  assign interrupter = r_interrupter;
  assign in_service  = r_in_service;
  assign irq_id      = r_id;
  assign irq_pending = r_pending;
  assign irq_lost    = r_lost;

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised and directed bench for irq_ctrl against a cycle-indexed model
// built from sampled source history and the request/ack/eret rules.
module tb_irq_ctrl;
  localparam int N = 4;
  localparam int S = 2;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] irq_src = '0;
  logic [N-1:0] irq_mask = '1;
  logic         irq_ack = 1'b0;
  logic         irq_eret = 1'b0;
  logic         interrupter;
  logic [W-1:0] irq_id;
  logic         in_service;
  logic [N-1:0] irq_pending;
  logic [7:0]   irq_lost;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: every source sample since reset release, plus handshake state
  logic [N-1:0] smp[$];
  logic [N-1:0] m_pend;
  int           m_lost;
  int           m_mode;  // 0 idle, 1 requesting, 2 in service
  int           m_id;

  irq_ctrl #(.N_SRC(N), .SYNC_STAGES(S), .ID_W(W)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .irq_mask(irq_mask),
    .irq_ack(irq_ack), .irq_eret(irq_eret), .interrupter(interrupter),
    .irq_id(irq_id), .in_service(in_service), .irq_pending(irq_pending),
    .irq_lost(irq_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    smp.delete();
    m_pend = '0;
    m_lost = 0;
    m_mode = 0;
    m_id   = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] e, clr, cand;
    int n;
    smp.push_back(irq_src);
    n = smp.size();
    // a rising edge seen by the core side S samples late; both samples must postdate reset
    e = '0;
    if (n >= S + 2) e = smp[n-S-1] & ~smp[n-S-2];
    clr = '0;
    if (m_mode == 1 && irq_ack) clr[m_id] = 1'b1;
    for (int i = 0; i < N; i++)
      if (e[i] && m_pend[i] && !clr[i] && m_lost < 255) m_lost++;
    cand = m_pend & irq_mask;
    case (m_mode)
      0: if (cand != 0) begin
           m_mode = 1;
           for (int i = N - 1; i >= 0; i--) if (cand[i]) m_id = i;
         end
      1: if (irq_ack) m_mode = 2;
      default: if (irq_eret) m_mode = 0;
    endcase
    m_pend = (m_pend & ~clr) | e;
  endtask

  task automatic do_cycle();
    @(posedge clk);
    if (rst) model_step();
    #1;
    check("interrupter", 32'(interrupter), 32'(m_mode == 1));
    check("in_service",  32'(in_service),  32'(m_mode == 2));
    check("irq_id",      32'(irq_id),      32'(m_id));
    check("irq_pending", 32'(irq_pending), 32'(m_pend));
    check("irq_lost",    32'(irq_lost),    32'(m_lost));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; do_cycle(); irq_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    irq_eret = 1'b1; do_cycle(); irq_eret = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_interrupter", 32'(interrupter), 32'd0);
    check("reset_pending",     32'(irq_pending), 32'd0);
    cycles(3);
    rst = 1'b1;
    cycles(6);

    // single source: latency of pending, request, ack and eret
    irq_src = 4'b0100;
    cycles(2);
    check("t1_pending_early", 32'(irq_pending), 32'd0);
    do_cycle();
    check("t1_pending", 32'(irq_pending), 32'b0100);
    do_cycle();
    check("t1_req", 32'(interrupter), 32'd1);
    check("t1_id",  32'(irq_id), 32'd2);
    cycles(5);
    pulse_ack();
    check("t1_ack_int", 32'(interrupter), 32'd0);
    check("t1_ack_svc", 32'(in_service), 32'd1);
    check("t1_ack_pend", 32'(irq_pending), 32'd0);
    cycles(4);
    pulse_eret();
    check("t1_eret_svc", 32'(in_service), 32'd0);
    irq_src = '0;
    cycles(4);

    // simultaneous sources 3 and 1: lowest index first, one idle cycle between
    irq_src = 4'b1010;
    cycles(4);
    check("t2_id_first", 32'(irq_id), 32'd1);
    pulse_ack();
    cycles(2);
    pulse_eret();
    check("t2_gap", 32'(interrupter), 32'd0);
    do_cycle();
    check("t2_req2", 32'(interrupter), 32'd1);
    check("t2_id2", 32'(irq_id), 32'd3);
    pulse_ack();
    pulse_eret();
    irq_src = '0;
    cycles(3);

    // masked edge stays latched until the mask opens
    irq_mask = 4'b1110;
    irq_src  = 4'b0001;
    cycles(6);
    check("t3_pend0", 32'(irq_pending[0]), 32'd1);
    check("t3_noreq", 32'(interrupter), 32'd0);
    irq_mask = 4'hF;
    cycles(2);
    check("t3_req", 32'(interrupter), 32'd1);
    check("t3_id",  32'(irq_id), 32'd0);
    pulse_ack();
    pulse_eret();
    irq_src = '0;
    cycles(3);

    // latched id is not re-arbitrated while requesting
    irq_src = 4'b0100;
    cycles(4);
    irq_src  = 4'b0101;
    irq_mask = 4'b1011;
    cycles(6);
    check("t4_id",  32'(irq_id), 32'd2);
    check("t4_req", 32'(interrupter), 32'd1);
    pulse_ack();
    pulse_eret();
    cycles(3);
    check("t6_pre_req", 32'(interrupter), 32'd1);

    // asynchronous reset mid-cycle while requesting; held-high lines give no edge
    #2 rst = 1'b0;
    #1;
    check("t6_int",  32'(interrupter), 32'd0);
    check("t6_pend", 32'(irq_pending), 32'd0);
    check("t6_lost", 32'(irq_lost), 32'd0);
    model_reset();
    irq_src  = 4'hF;
    irq_mask = 4'hF;
    cycles(2);
    rst = 1'b1;
    cycles(20);
    check("t6_noreq", 32'(interrupter), 32'd0);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
      if ($urandom_range(0, 15) == 0) irq_mask = N'($urandom);
      else if ($urandom_range(0, 15) == 0) irq_mask = '1;
      irq_ack  = ($urandom_range(0, 2) == 0);
      irq_eret = ($urandom_range(0, 3) == 0);
      do_cycle();
    end
    irq_ack  = 1'b0;
    irq_eret = 1'b0;

    // hammer one source with nothing serviced until the lost counter saturates
    irq_mask = '0;
    irq_src  = '0;
    for (int c = 0; c < 600; c++) begin
      irq_src[1] = ~irq_src[1];
      do_cycle();
    end
    check("sat_lost", 32'(irq_lost), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
